// File: rtl/mem_stage_hs.sv
// mem_stage_hs: WISC memory stage that resolves branch conditions, runs req/ack data memory
// accesses with stall and timeout, flags misaligned accesses and sequences the halt dump.
module mem_stage_hs #(
    parameter int   DW        = 16,
    parameter logic ALIGN_CHK = 1'b1,
    parameter int   MAX_WAIT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic          halt,
    input  logic          branch,
    input  logic          jump,
    input  logic [2:0]    sel_flag,
    input  logic          ofl,
    input  logic          z,
    input  logic          n,
    input  logic          cout,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] store_data,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_dump,
    output logic [DW-1:0] read_data,
    output logic          stall,
    output logic          condition,
    output logic          pc_sel,
    output logic          err
);
    typedef enum logic [2:0] {IDLE, REQ, DONE, HALTED, FAULT} state_t;
    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          we_q, we_d, dump_q, dump_d;
    logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic          memop, misal, acc, lt, timeout;
    assign memop   = valid_in & (mem_rd | mem_wr);
    assign misal   = ALIGN_CHK & alu_result[0] & memop;
    assign acc     = memop & ~misal;
    assign lt      = n ^ ofl;
    // the ack seen in the cycle the count would reach MAX_WAIT still wins
    assign timeout = (cnt_q + 8'd1) == 8'(MAX_WAIT);
    assign condition = (sel_flag == 3'b000) ? z :
                       (sel_flag == 3'b001) ? lt :
                       (sel_flag == 3'b010) ? (lt | z) :
                       (sel_flag == 3'b011) ? ~z :
                       (sel_flag == 3'b100) ? ~lt : cout;
    assign pc_sel    = valid_in & ((branch & condition) | jump);
    assign mem_req   = state_q == REQ;
    assign err       = state_q == FAULT;
    assign stall     = ((state_q == IDLE) & acc) | mem_req | err;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign read_data = rdata_q;
    assign mem_dump  = dump_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        dump_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (misal) begin
                    state_d = FAULT;
                end else if (acc) begin
                    state_d = REQ;
                    cnt_d   = 8'd0;
                    we_d    = mem_wr;
                    addr_d  = alu_result;
                    wdata_d = store_data;
                end else if (valid_in & halt) begin
                    state_d = HALTED;
                    dump_d  = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = DONE;
                    rdata_d = we_q ? rdata_q : mem_rdata;
                end else if (timeout) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            dump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            dump_q  <= dump_d;
        end
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed scoreboard bench for mem_stage_hs with MAX_WAIT=4.
module tb_mem_stage_hs;
    localparam int EV_REQ = 0, EV_DONE = 1, EV_DUMP = 2, EV_ERR = 3;
    logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, halt = 1'b0;
    logic branch = 1'b0, jump = 1'b0, ofl = 1'b0, z = 1'b0, n = 1'b0, cout = 1'b0, mem_ack = 1'b0;
    logic [2:0]  sel_flag = 3'b000;
    logic [15:0] alu_result = '0, store_data = '0, mem_rdata = '0;
    logic        mem_req, mem_we, mem_dump, stall, condition, pc_sel, err;
    logic [15:0] mem_addr, mem_wdata, read_data;
    typedef struct {int kind; logic we; logic [15:0] a; logic [15:0] d; logic [15:0] r;} ev_t;
    ev_t         exp_q[$];
    int          vectors = 0, miscompares = 0;
    logic [15:0] rd_model = '0;
    logic        pr = 1'b0, pe = 1'b0;
    mem_stage_hs #(.DW(16), .ALIGN_CHK(1'b1), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .halt(halt), .branch(branch), .jump(jump), .sel_flag(sel_flag), .ofl(ofl), .z(z),
        .n(n), .cout(cout), .alu_result(alu_result), .store_data(store_data),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dump(mem_dump),
        .read_data(read_data), .stall(stall), .condition(condition), .pc_sel(pc_sel), .err(err)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic push(input int kind, input logic we, input logic [15:0] a, d, r);
        ev_t e;
        e.kind = kind; e.we = we; e.a = a; e.d = d; e.r = r;
        exp_q.push_back(e);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic reset_dut();
        rst = 1'b1; valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; halt = 1'b0; mem_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        rd_model = '0;
    endtask
    // ack pulses in the k-th REQ cycle; counts stall and req cycles up to and including DONE
    task automatic access(input logic wr, input logic [15:0] a, d, input int k,
                          input logic [15:0] rd, input string nm);
        int s = 0, r = 0;
        push(EV_REQ, wr, a, d, '0);
        if (!wr) rd_model = rd;
        push(EV_DONE, 1'b0, '0, '0, rd_model);
        valid_in = 1'b1; mem_rd = !wr; mem_wr = wr; alu_result = a; store_data = d; mem_rdata = rd;
        for (int c = 0; c <= k + 1; c++) begin
            if (c > 0) tick();
            mem_ack = (c == k);
            @(negedge clk);
            s += int'(stall);
            r += int'(mem_req);
        end
        tick();
        mem_ack = 1'b0; valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        check({nm, "_stall_cycles"}, s, k + 1);
        check({nm, "_req_cycles"}, r, k);
    endtask
    initial begin
        ev_t e;
        int  kind;
        forever begin
            @(negedge clk);
            kind = -1;
            if (mem_req & ~pr) kind = EV_REQ;
            else if (pr & ~mem_req & ~err) kind = EV_DONE;
            else if (mem_dump) kind = EV_DUMP;
            else if (err & ~pe) kind = EV_ERR;
            if (kind >= 0) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_event: got kind %0d, expected no event", kind);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_kind", kind, e.kind);
                    case (e.kind)
                        EV_REQ: begin
                            check("req_we", mem_we, e.we);
                            check("req_addr", mem_addr, e.a);
                            check("req_wdata", mem_wdata, e.d);
                        end
                        EV_DONE: begin
                            check("done_read_data", read_data, e.r);
                            check("done_stall", stall, 0);
                        end
                        EV_ERR:  check("fault_req", mem_req, 0);
                        default: check("dump_err", err, 0);
                    endcase
                end
            end
            pr = mem_req;
            pe = err;
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        logic [7:0] tbl [11] = '{8'b001_1000_1, 8'b001_1100_0, 8'b100_1100_1, 8'b100_1000_0,
                                 8'b000_0010_1, 8'b010_0010_1, 8'b010_1100_0, 8'b011_0010_0,
                                 8'b011_0000_1, 8'b101_0001_1, 8'b111_0000_0};
        logic [7:0] t;
        int d, s, r, ec;
        reset_dut();
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_read_data", read_data, 0);
        check("rst_mem_dump", mem_dump, 0);
        check("rst_err", err, 0);
        check("rst_stall", stall, 0);
        tick();
        access(1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, "load");
        access(1'b1, 16'h0020, 16'h1234, 1, 16'hDEAD, "store");
        check("store_keeps_read_data", read_data, 16'hBEEF);
        access(1'b0, 16'h0040, 16'h0000, 4, 16'h5A5A, "ack_at_limit");
        check("ack_at_limit_err", err, 0);
        valid_in = 1'b1; branch = 1'b1;
        for (int i = 0; i < 11; i++) begin
            t = tbl[i];
            sel_flag = t[7:5]; n = t[4]; ofl = t[3]; z = t[2]; cout = t[1];
            #1;
            check($sformatf("cond_%0d", i), condition, t[0]);
            check($sformatf("pc_sel_%0d", i), pc_sel, t[0]);
        end
        sel_flag = 3'b001; n = 1'b1; ofl = 1'b0; z = 1'b0; cout = 1'b0; valid_in = 1'b0;
        #1;
        check("pc_sel_invalid", pc_sel, 0);
        valid_in = 1'b1; branch = 1'b0; jump = 1'b1; sel_flag = 3'b000;
        #1;
        check("jump_cond", condition, 0);
        check("jump_pc_sel", pc_sel, 1);
        valid_in = 1'b0; jump = 1'b0; n = 1'b0;
        tick();
        push(EV_REQ, 1'b0, 16'h0030, 16'h0000, '0);
        push(EV_ERR, 1'b0, '0, '0, '0);
        valid_in = 1'b1; mem_rd = 1'b1; alu_result = 16'h0030; store_data = 16'h0000;
        r = 0; ec = 0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            r += int'(mem_req);
            ec += int'(err);
        end
        check("timeout_req_cycles", r, 4);
        check("timeout_err_cycles", ec, 1);
        check("timeout_stall", stall, 1);
        reset_dut();
        push(EV_ERR, 1'b0, '0, '0, '0);
        valid_in = 1'b1; mem_rd = 1'b1; alu_result = 16'h0011;
        @(negedge clk);
        check("misal_first_stall", stall, 0);
        r = 0; s = 0; ec = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            @(negedge clk);
            r += int'(mem_req);
            s += int'(stall);
            ec += int'(err);
        end
        check("misal_req_cycles", r, 0);
        check("misal_stall_cycles", s, 4);
        check("misal_err_cycles", ec, 4);
        reset_dut();
        @(negedge clk);
        check("misal_err_after_rst", err, 0);
        tick();
        push(EV_DUMP, 1'b0, '0, '0, '0);
        valid_in = 1'b1; halt = 1'b1;
        tick();
        valid_in = 1'b0; halt = 1'b0;
        d = 0; s = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            d += int'(mem_dump);
            s += int'(stall);
            tick();
        end
        check("halt_dump_pulses", d, 1);
        check("halt_stall_cycles", s, 0);
        valid_in = 1'b1; mem_rd = 1'b1; alu_result = 16'h0050;
        r = 0; s = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            r += int'(mem_req);
            s += int'(stall);
            tick();
        end
        check("halted_req_cycles", r, 0);
        check("halted_stall_cycles", s, 0);
        reset_dut();
        push(EV_REQ, 1'b0, 16'h0060, 16'h0000, '0);
        push(EV_DONE, 1'b0, '0, '0, 16'h0000);
        valid_in = 1'b1; mem_rd = 1'b1; alu_result = 16'h0060; store_data = 16'h0000;
        tick();
        tick();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h7777; valid_in = 1'b0; mem_rd = 1'b0;
        tick();
        rst = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_read_data", read_data, 0);
        check("rst_mid_stall", stall, 0);
        rd_model = '0;
        tick();
        access(1'b0, 16'h0070, 16'h0000, 1, 16'h1111, "post_rst");
        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
